// File: rtl/reg_cmd_ctrl_if.sv
// rtl/reg_cmd_ctrl_if.sv - UART byte stream, register file and TX handshake bundle for reg_cmd_ctrl
// master: the command controller; slave: the UART/register-file side.
interface reg_cmd_ctrl_if #(
  parameter int data_width   = 8,
  parameter int address_bits = 4
);
  logic [data_width-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [data_width-1:0]   RdData;
  logic                    WrEn;
  logic                    RdEn;
  logic [address_bits-1:0] Address;
  logic [data_width-1:0]   WrData;
  logic [data_width-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    TX_READY;
  logic                    CMD_ERR;
  logic                    BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, TX_READY,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, BUSY
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, TX_READY,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, BUSY
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// rtl/reg_cmd_ctrl.sv - framed write/read command decoder in front of the register file
// Optional inter-byte timeout enabled by defining REG_CMD_TIMEOUT_EN.
module reg_cmd_ctrl #(
  parameter int              data_width     = 8,
  parameter int              address_bits   = 4,
  parameter int              regno          = 16,
  parameter logic [7:0]      WR_CMD         = 8'hAA,
  parameter logic [7:0]      RD_CMD         = 8'hBB
`ifdef REG_CMD_TIMEOUT_EN
  ,
  parameter int              TIMEOUT_CYCLES = 1024
`endif
) (
  input logic              CLK,
  input logic              RST,
  reg_cmd_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_TX_SEND
  } state_t;

  localparam logic [data_width:0] REGNO_L = (data_width + 1)'(regno);

  state_t                  r_state, w_state_nxt;
  logic                    r_wren, w_wren_nxt;
  logic                    r_rden, w_rden_nxt;
  logic                    r_err, w_err_nxt;
  logic [address_bits-1:0] r_addr, w_addr_nxt;
  logic [data_width-1:0]   r_wrdata, w_wrdata_nxt;
  logic [data_width-1:0]   r_txdata, w_txdata_nxt;
  logic                    r_txvld, w_txvld_nxt;
  logic                    w_vld;
  logic [data_width-1:0]   w_byte;
  logic                    w_addr_ok;
  logic                    w_timeout;

  assign w_vld     = bus.RX_D_VLD;
  assign w_byte    = bus.RX_P_DATA;
  assign w_addr_ok = ({1'b0, w_byte} < REGNO_L);

`ifdef REG_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          w_waiting;

  assign w_waiting = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) || (r_state == S_RD_ADDR);
  assign w_timeout = w_waiting && !w_vld && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts consecutive byte-less cycles while a frame is half received.
  always_ff @(posedge CLK) begin
    if (RST || !w_waiting || w_vld || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_wren_nxt   = 1'b0;
    w_rden_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_addr_nxt   = r_addr;
    w_wrdata_nxt = r_wrdata;
    w_txdata_nxt = r_txdata;
    w_txvld_nxt  = r_txvld;
    case (r_state)
      S_IDLE: begin
        if (w_vld) begin
          if (w_byte == WR_CMD) begin
            w_state_nxt = S_WR_ADDR;
          end else if (w_byte == RD_CMD) begin
            w_state_nxt = S_RD_ADDR;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_WR_ADDR: begin
        if (w_vld) begin
          if (w_addr_ok) begin
            w_addr_nxt  = w_byte[address_bits-1:0];
            w_state_nxt = S_WR_DATA;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (w_vld) begin
          w_wrdata_nxt = w_byte;
          w_wren_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (w_vld) begin
          if (w_addr_ok) begin
            // RdEn is registered, so it is high for the whole RD_ISSUE cycle.
            w_addr_nxt  = w_byte[address_bits-1:0];
            w_rden_nxt  = 1'b1;
            w_state_nxt = S_RD_ISSUE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        w_err_nxt   = w_vld;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_err_nxt    = w_vld;
        w_txdata_nxt = bus.RdData;
        w_txvld_nxt  = 1'b1;
        w_state_nxt  = S_TX_SEND;
      end
      S_TX_SEND: begin
        w_err_nxt = w_vld;
        if (r_txvld && bus.TX_READY) begin
          w_txvld_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txvld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_wren   <= 1'b0;
      r_rden   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wrdata <= '0;
      r_txdata <= '0;
      r_txvld  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wren   <= w_wren_nxt;
      r_rden   <= w_rden_nxt;
      r_err    <= w_err_nxt;
      r_addr   <= w_addr_nxt;
      r_wrdata <= w_wrdata_nxt;
      r_txdata <= w_txdata_nxt;
      r_txvld  <= w_txvld_nxt;
    end
  end

  assign bus.WrEn      = r_wren;
  assign bus.RdEn      = r_rden;
  assign bus.Address   = r_addr;
  assign bus.WrData    = r_wrdata;
  assign bus.TX_P_DATA = r_txdata;
  assign bus.TX_D_VLD  = r_txvld;
  assign bus.CMD_ERR   = r_err;
  assign bus.BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb/tb_reg_cmd_ctrl.sv - scoreboard bench for reg_cmd_ctrl with a register file model
// Covers the timeout frame when REG_CMD_TIMEOUT_EN is defined.
module tb_reg_cmd_ctrl;

  localparam int EV_ERR = 0;
  localparam int EV_WR  = 1;
  localparam int EV_RD  = 2;
  localparam int EV_TX  = 3;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  logic [7:0] mem [16];

  reg_cmd_ctrl_if #(.data_width(8), .address_bits(4)) bif ();

  reg_cmd_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bif)
  );

  always #5 CLK = ~CLK;

  // Register file: write and read both registered.
  always @(posedge CLK) begin
    if (bif.WrEn) mem[bif.Address] <= bif.WrData;
    if (bif.RdEn) bif.RdData <= mem[bif.Address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind ||
          ((kind == EV_WR || kind == EV_RD) && e.addr != a) ||
          ((kind == EV_WR || kind == EV_TX) && e.data != d)) begin
        n_fail++;
        $display("FAIL event: got kind %0d addr %0h data %0h expected kind %0d addr %0h data %0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (bif.CMD_ERR) pop_cmp(EV_ERR, 8'h00, 8'h00);
      if (bif.WrEn) pop_cmp(EV_WR, {4'h0, bif.Address}, bif.WrData);
      if (bif.RdEn) pop_cmp(EV_RD, {4'h0, bif.Address}, 8'h00);
      if (bif.TX_D_VLD && bif.TX_READY) pop_cmp(EV_TX, 8'h00, bif.TX_P_DATA);
      if (bif.WrEn && bif.RdEn) chk("wren_rden_exclusive", 32'd1, 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bif.RX_P_DATA = b;
    bif.RX_D_VLD  = 1'b1;
    tick();
    bif.RX_D_VLD  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    push(EV_WR, a, d);
    send(8'hAA);
    chk("wr_busy", bif.BUSY, 1);
    send(a);
    send(d);
    chk("wr_wren_latency", bif.WrEn, 1);
    chk("wr_wrdata", bif.WrData, d);
    chk("wr_back_idle", bif.BUSY, 0);
    tick();
    chk("wr_wren_pulse", bif.WrEn, 0);
  endtask

  task automatic read_fast(input logic [7:0] a, input logic [7:0] d);
    push(EV_RD, a, 8'h00);
    push(EV_TX, 8'h00, d);
    bif.TX_READY = 1'b1;
    send(8'hBB);
    send(a);
    chk("rd_rden_latency", bif.RdEn, 1);
    tick();
    chk("rd_rden_pulse", bif.RdEn, 0);
    chk("rd_txvld_early", bif.TX_D_VLD, 0);
    tick();
    chk("rd_txvld_latency", bif.TX_D_VLD, 1);
    chk("rd_txdata", bif.TX_P_DATA, d);
    tick();
    chk("rd_txvld_clear", bif.TX_D_VLD, 0);
    chk("rd_back_idle", bif.BUSY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bif.RX_P_DATA = 8'h00;
    bif.RX_D_VLD  = 1'b0;
    bif.TX_READY  = 1'b0;
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    chk("rst_wren", bif.WrEn, 0);
    chk("rst_rden", bif.RdEn, 0);
    chk("rst_txvld", bif.TX_D_VLD, 0);
    chk("rst_cmd_err", bif.CMD_ERR, 0);
    chk("rst_busy", bif.BUSY, 0);
    chk("rst_address", bif.Address, 0);
    chk("rst_wrdata", bif.WrData, 0);
    chk("rst_txdata", bif.TX_P_DATA, 0);

    do_write(8'h03, 8'h5C);
    read_fast(8'h03, 8'h5C);

    // Back-pressured read with a stray byte while the result is pending.
    do_write(8'h07, 8'hA5);
    bif.TX_READY = 1'b0;
    push(EV_RD, 8'h07, 8'h00);
    send(8'hBB);
    send(8'h07);
    chk("bp_rden", bif.RdEn, 1);
    tick();
    tick();
    push(EV_ERR, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      chk("bp_txvld_hold", bif.TX_D_VLD, 1);
      chk("bp_txdata_hold", bif.TX_P_DATA, 8'hA5);
      if (i == 4) begin
        bif.RX_P_DATA = 8'h11;
        bif.RX_D_VLD  = 1'b1;
      end
      tick();
      bif.RX_D_VLD = 1'b0;
    end
    push(EV_TX, 8'h00, 8'hA5);
    bif.TX_READY = 1'b1;
    tick();
    bif.TX_READY = 1'b0;
    chk("bp_txvld_clear", bif.TX_D_VLD, 0);
    chk("bp_back_idle", bif.BUSY, 0);

    // Unknown command, then out-of-range address.
    push(EV_ERR, 8'h00, 8'h00);
    send(8'h42);
    chk("unk_busy", bif.BUSY, 0);
    push(EV_ERR, 8'h00, 8'h00);
    send(8'hAA);
    send(8'h10);
    chk("oob_idle", bif.BUSY, 0);
    tick();

    // Reset mid-frame discards the frame.
    send(8'hAA);
    send(8'h05);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_busy", bif.BUSY, 0);
    chk("midrst_address", bif.Address, 0);
    push(EV_ERR, 8'h00, 8'h00);
    send(8'h77);
    chk("midrst_idle", bif.BUSY, 0);
    tick();

    // Highest address and a command value used as data.
    do_write(8'h0F, 8'h3C);
    read_fast(8'h0F, 8'h3C);
    do_write(8'h01, 8'hBB);
    read_fast(8'h01, 8'hBB);

`ifdef REG_CMD_TIMEOUT_EN
    push(EV_ERR, 8'h00, 8'h00);
    send(8'hAA);
    cnt = 0;
    while (bif.BUSY && cnt < 1200) begin
      tick();
      cnt++;
    end
    chk("timeout_idle", bif.BUSY, 0);
    chk("timeout_cycles", cnt, 1024);
    chk("timeout_no_wren", bif.WrEn, 0);
    read_fast(8'h01, 8'hBB);
`endif

    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
Name: reg_cmd_ctrl

Overview:
- Command front-end that sits directly upstream of the register file.
- Consumes a byte stream from the UART receiver and decodes framed write/read commands.
- Drives the register file's WrEn/RdEn/Address/WrData, captures its registered RdData, and hands read results to the UART transmitter over a valid/ready handshake.

Parameters:
- data_width, 8, width of data bytes, WrData/RdData and TX data
- address_bits, 4, register file address width
- regno, 16, number of implemented registers; address bytes >= regno are rejected
- WR_CMD, 8'hAA, command byte for a write frame (CMD, ADDR, DATA)
- RD_CMD, 8'hBB, command byte for a read frame (CMD, ADDR)
- TIMEOUT_CYCLES, 1024, max idle cycles between bytes of one frame (optional feature only)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- RX_P_DATA  in  data_width  received byte
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid this cycle
- RdData  in  data_width  register file read data, valid the cycle after RdEn
- WrEn  out  1  register file write enable, one-cycle pulse
- RdEn  out  1  register file read enable, one-cycle pulse
- Address  out  address_bits  register file address
- WrData  out  data_width  register file write data
- TX_P_DATA  out  data_width  read result to transmitter
- TX_D_VLD  out  1  TX_P_DATA valid; held until accepted
- TX_READY  in  1  transmitter accepts when TX_D_VLD && TX_READY
- CMD_ERR  out  1  one-cycle pulse on a rejected byte or frame
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (RST high at a CLK edge) overrides everything. All outputs go to 0 and the state goes to IDLE, including mid-frame or mid-TX. Any pending TX data is discarded.
- Bytes are consumed only on cycles where RX_D_VLD=1. Other cycles hold the current state.
- States and transitions:
  - IDLE:
    - byte==WR_CMD -> WR_ADDR
    - byte==RD_CMD -> RD_ADDR
    - any other byte -> pulse CMD_ERR, stay in IDLE
  - WR_ADDR: byte<regno -> latch Address=byte[address_bits-1:0], go to WR_DATA. Otherwise pulse CMD_ERR and go to IDLE.
  - WR_DATA: on byte, WrData<=byte and WrEn=1 for exactly the next cycle, then IDLE.
  - RD_ADDR: byte<regno -> latch Address, go to RD_ISSUE. Otherwise pulse CMD_ERR and go to IDLE.
  - RD_ISSUE: RdEn=1 for one cycle, go to RD_WAIT. Ignores RX_D_VLD.
  - RD_WAIT: capture RdData into TX_P_DATA, set TX_D_VLD=1, go to TX_SEND.
  - TX_SEND: hold TX_P_DATA and TX_D_VLD. On TX_D_VLD&&TX_READY, clear TX_D_VLD next cycle and go to IDLE.
- Bytes arriving in RD_ISSUE, RD_WAIT or TX_SEND are dropped and each pulses CMD_ERR. There is no buffering.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their last value outside their pulses.
- Latency:
  - Write: last RX_D_VLD edge to WrEn high = 1 cycle.
  - Read: ADDR byte edge to RdEn = 1 cycle; to TX_D_VLD = 3 cycles.
- A command byte value arriving as ADDR or DATA is treated as ADDR/DATA, not as a new command.

Optional Feature:
- Macro: REG_CMD_TIMEOUT_EN.
- When defined:
  - A counter runs in WR_ADDR, WR_DATA and RD_ADDR, cleared on each accepted byte.
  - When it reaches TIMEOUT_CYCLES, pulse CMD_ERR, return to IDLE, and issue no WrEn/RdEn.
- When undefined:
  - No counter logic.
  - The FSM waits indefinitely for the next frame byte.

Test Plan:
- Reset, then bytes AA,03,5C -> WrEn=1 for one cycle, Address=3, WrData=8'h5C, CMD_ERR never high, back in IDLE.
- Bytes BB,03 with RdData=8'h5C and TX_READY=1 -> RdEn pulse, TX_D_VLD with TX_P_DATA=8'h5C 3 cycles after ADDR byte, accepted in one cycle.
- Read with TX_READY=0 for 10 cycles -> TX_D_VLD and TX_P_DATA stable all 10 cycles; extra RX byte 8'h11 in that window -> CMD_ERR pulse, byte dropped; TX_READY=1 -> IDLE.
- Byte 8'h42 in IDLE -> CMD_ERR pulse; then AA,10 (16>=regno) -> CMD_ERR, no WrEn, IDLE.
- AA,05 then RST high one cycle, then 77 -> no WrEn; 77 treated as unknown command (CMD_ERR).
- With REG_CMD_TIMEOUT_EN: AA, then 1024 idle cycles -> CMD_ERR, IDLE; a following BB,01 completes a normal read.
